// File: rtl/uram_arbiter_pkg.sv
// Shared types for the UltraRAM arbiter: controller state and client identity.
package uram_arbiter_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer value to register.
module rr_arbiter2
  import uram_arbiter_pkg::*;
(
  input  logic       enable,
  input  logic [1:0] req,
  input  client_e    ptr,
  output logic [1:0] grant,
  output client_e    ptr_next
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant    = 2'b00;
    ptr_next = ptr;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ptr == CLIENT_A) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
      // The winner goes to the back of the line.
      if (grant[0]) begin
        ptr_next = CLIENT_B;
      end else if (grant[1]) begin
        ptr_next = CLIENT_A;
      end
    end
  end

endmodule

// File: rtl/uram_arbiter.sv
// Zero-fill controller and dual round-robin port arbiter in front of one
// simple-dual-port, read-first, 1-cycle-latency memory.
module uram_arbiter
  import uram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  output logic                     busy,

  input  logic                     a_rd_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_rd_addr,
  output logic                     a_rd_ready,
  output logic                     a_rd_rsp_valid,
  input  logic                     a_wr_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_wr_addr,
  input  logic [DATA_WIDTH-1:0]    a_wr_data,
  output logic                     a_wr_ready,

  input  logic                     b_rd_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_rd_addr,
  output logic                     b_rd_ready,
  output logic                     b_rd_rsp_valid,
  input  logic                     b_wr_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_wr_addr,
  input  logic [DATA_WIDTH-1:0]    b_wr_data,
  output logic                     b_wr_ready,

  output logic [DATA_WIDTH-1:0]    rd_rsp_data,

  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  output logic                     mem_wen,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  state_e                     state, state_next;
  logic [ADDRESS_WIDTH-1:0]   fill_count;
  client_e                    rd_ptr, rd_ptr_next;
  client_e                    wr_ptr, wr_ptr_next;
  logic [1:0]                 rd_grant, wr_grant;
  logic                       run;

  assign run = (state == RUN);

  rr_arbiter2 u_rd_arb (
    .enable   (run),
    .req      ({b_rd_valid, a_rd_valid}),
    .ptr      (rd_ptr),
    .grant    (rd_grant),
    .ptr_next (rd_ptr_next)
  );

  rr_arbiter2 u_wr_arb (
    .enable   (run),
    .req      ({b_wr_valid, a_wr_valid}),
    .ptr      (wr_ptr),
    .grant    (wr_grant),
    .ptr_next (wr_ptr_next)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clear is only honoured in RUN.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (fill_count == LAST_ADDR) state_next = RUN;
      RUN:     if (clear) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Fill counter wraps to 0 on the last address, ready for the next clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_count     <= '0;
      rd_ptr         <= CLIENT_A;
      wr_ptr         <= CLIENT_A;
      a_rd_rsp_valid <= 1'b0;
      b_rd_rsp_valid <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        fill_count <= fill_count + 1'b1;
      end
      rd_ptr         <= rd_ptr_next;
      wr_ptr         <= wr_ptr_next;
      a_rd_rsp_valid <= rd_grant[0];
      b_rd_rsp_valid <= rd_grant[1];
    end
  end

  // Output logic: zero-fill drives the write port, otherwise the granted client does.
  always_comb begin
    busy       = 1'b0;
    a_rd_ready = rd_grant[0];
    b_rd_ready = rd_grant[1];
    a_wr_ready = wr_grant[0];
    b_wr_ready = wr_grant[1];
    mem_raddr  = '0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_din    = '0;
    if (state == CLEAR) begin
      busy      = 1'b1;
      mem_wen   = 1'b1;
      mem_waddr = fill_count;
    end else begin
      if (rd_grant[0]) begin
        mem_raddr = a_rd_addr;
      end else if (rd_grant[1]) begin
        mem_raddr = b_rd_addr;
      end
      mem_wen = |wr_grant;
      if (wr_grant[0]) begin
        mem_waddr = a_wr_addr;
        mem_din   = a_wr_data;
      end else if (wr_grant[1]) begin
        mem_waddr = b_wr_addr;
        mem_din   = b_wr_data;
      end
    end
  end

  assign rd_rsp_data = mem_dout;

endmodule

// File: tb/tb_uram_arbiter.sv
// Randomised scoreboard bench for uram_arbiter with a behavioural memory and
// a reference model of fill, round-robin grants and read-first memory contents.
module tb_uram_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          busy;
  logic          a_rd_valid, b_rd_valid, a_wr_valid, b_wr_valid;
  logic [AW-1:0] a_rd_addr, b_rd_addr, a_wr_addr, b_wr_addr;
  logic [DW-1:0] a_wr_data, b_wr_data;
  logic          a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready;
  logic          a_rd_rsp_valid, b_rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_wen;
  logic [DW-1:0] mem_din, mem_dout;

  uram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .clear          (clear),
    .busy           (busy),
    .a_rd_valid     (a_rd_valid),
    .a_rd_addr      (a_rd_addr),
    .a_rd_ready     (a_rd_ready),
    .a_rd_rsp_valid (a_rd_rsp_valid),
    .a_wr_valid     (a_wr_valid),
    .a_wr_addr      (a_wr_addr),
    .a_wr_data      (a_wr_data),
    .a_wr_ready     (a_wr_ready),
    .b_rd_valid     (b_rd_valid),
    .b_rd_addr      (b_rd_addr),
    .b_rd_ready     (b_rd_ready),
    .b_rd_rsp_valid (b_rd_rsp_valid),
    .b_wr_valid     (b_wr_valid),
    .b_wr_addr      (b_wr_addr),
    .b_wr_data      (b_wr_data),
    .b_wr_ready     (b_wr_ready),
    .rd_rsp_data    (rd_rsp_data),
    .mem_raddr      (mem_raddr),
    .mem_wen        (mem_wen),
    .mem_waddr      (mem_waddr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout)
  );

  always #5 clock = ~clock;

  // Memory instance: read-first, one cycle of read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (mem_wen) mem[mem_waddr] <= mem_din;
    mem_dout <= mem[mem_raddr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: fill position (-1 = running), grant pointers, contents.
  typedef struct {
    int            client;
    logic [DW-1:0] data;
  } rsp_t;

  int            fill_idx;
  int            rd_ptr, wr_ptr;
  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          exp_q [$];

  function automatic int pick(input logic va, input logic vb, input int ptr);
    if (va && vb) return ptr;
    if (va) return 0;
    if (vb) return 1;
    return -1;
  endfunction

  // One clock cycle: drive at the falling edge, predict and check, then wait.
  task automatic cycle(input logic av, input logic [AW-1:0] aa,
                       input logic bv, input logic [AW-1:0] ba,
                       input logic awv, input logic [AW-1:0] awa, input logic [DW-1:0] awd,
                       input logic bwv, input logic [AW-1:0] bwa, input logic [DW-1:0] bwd,
                       input logic clr);
    int            rg, wg;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    a_rd_valid = av;  a_rd_addr = aa;  b_rd_valid = bv;  b_rd_addr = ba;
    a_wr_valid = awv; a_wr_addr = awa; a_wr_data = awd;
    b_wr_valid = bwv; b_wr_addr = bwa; b_wr_data = bwd;
    clear = clr;
    #1;
    if (fill_idx >= 0) begin
      check("fill_busy", busy, 1);
      check("fill_readies", {a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready}, 0);
      check("fill_wen", mem_wen, 1);
      check("fill_waddr", mem_waddr, fill_idx);
      check("fill_din", mem_din, 0);
      ref_mem[fill_idx] = '0;
      fill_idx++;
      if (fill_idx == DEPTH) fill_idx = -1;
    end else begin
      check("run_busy", busy, 0);
      rg = pick(av, bv, rd_ptr);
      wg = pick(awv, bwv, wr_ptr);
      check("a_rd_ready", a_rd_ready, rg == 0);
      check("b_rd_ready", b_rd_ready, rg == 1);
      check("a_wr_ready", a_wr_ready, wg == 0);
      check("b_wr_ready", b_wr_ready, wg == 1);
      ra = (rg == 0) ? aa : (rg == 1) ? ba : '0;
      check("mem_raddr", mem_raddr, ra);
      if (rg >= 0) begin
        exp_q.push_back('{client: rg, data: ref_mem[ra]});
        rd_ptr = 1 - rg;
      end
      wa = (wg == 0) ? awa : (wg == 1) ? bwa : '0;
      wd = (wg == 0) ? awd : (wg == 1) ? bwd : '0;
      check("mem_wen", mem_wen, wg >= 0);
      check("mem_waddr", mem_waddr, wa);
      check("mem_din", mem_din, wd);
      if (wg >= 0) begin
        ref_mem[wa] = wd;
        wr_ptr = 1 - wg;
      end
      if (clr) fill_idx = 0;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all_a();
    for (int i = 0; i < DEPTH; i++) cycle(1, AW'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_cycles(input int n, input int clear_odds);
    for (int i = 0; i < n; i++)
      cycle(1'($urandom_range(1)), AW'($urandom), 1'($urandom_range(1)), AW'($urandom),
            1'($urandom_range(1)), AW'($urandom), $urandom,
            1'($urandom_range(1)), AW'($urandom), $urandom,
            (clear_odds > 0) && ($urandom_range(clear_odds - 1) == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_readies"}, {a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready}, 0);
    check({tag, "_rsp_valid"}, {a_rd_rsp_valid, b_rd_rsp_valid}, 0);
    check({tag, "_wen"}, mem_wen, 1);
    check({tag, "_waddr"}, mem_waddr, 0);
    check({tag, "_din"}, mem_din, 0);
    check({tag, "_raddr"}, mem_raddr, 0);
  endtask

  // Monitor: every queued read is due exactly at the next rising edge.
  always begin : monitor
    rsp_t e;
    @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("a_rd_rsp_valid", a_rd_rsp_valid, e.client == 0);
      check("b_rd_rsp_valid", b_rd_rsp_valid, e.client == 1);
      check("rd_rsp_data", rd_rsp_data, e.data);
    end else begin
      check("no_rsp_valid", {a_rd_rsp_valid, b_rd_rsp_valid}, 0);
    end
  end

  initial begin
    reset_n  = 1'b0;
    fill_idx = 0;
    rd_ptr   = 0;
    wr_ptr   = 0;
    a_rd_valid = 0; a_rd_addr = 0; b_rd_valid = 0; b_rd_addr = 0;
    a_wr_valid = 0; a_wr_addr = 0; a_wr_data = 0;
    b_wr_valid = 0; b_wr_addr = 0; b_wr_data = 0;
    clear = 0;
    #3;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Initial zero-fill with requests and a stray clear, all ignored.
    idle(5);
    cycle(1, 2, 1, 3, 1, 4, 32'hFFFF, 1, 5, 32'hAAAA, 1);
    idle(10);
    read_all_a();

    // A writes then reads address 3.
    cycle(0, 0, 0, 0, 1, 3, 32'hDEAD, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Contention on both ports, including several writes to one address.
    for (int i = 0; i < 6; i++)
      cycle(1, AW'(i), 1, AW'(i + 8), 1, 7, DW'(i + 32'h100), 1, 7, DW'(i + 32'h200), 0);
    cycle(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);

    // Read-first hazard on address 5.
    cycle(1, 5, 0, 0, 0, 0, 0, 1, 5, 32'h1, 0);
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    random_cycles(200, 0);

    // Clear pulsed alongside a granted B read, then fill under request pressure.
    cycle(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1);
    random_cycles(16, 0);
    read_all_a();

    random_cycles(400, 64);
    idle(DEPTH);

    // Reset asserted mid-fill at counter 9.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(9);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    exp_q.delete();
    fill_idx = 0;
    rd_ptr   = 0;
    wr_ptr   = 0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(DEPTH);
    read_all_a();
    random_cycles(100, 0);
    idle(2);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
